// File: rtl/uart_pkg.sv
// Purpose: shared UART constants, RX/TX state encoding and hex segment patterns.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_CLEANUP
  } uart_state_t;

  // Lit-segment patterns A..G (A = MSB), 1 = segment on.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Purpose: nibble to active-low 7-segment decoder (A = MSB).
// Latency: combinational.
// Backpressure: none.
module hex_to_7seg
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = ~SEG_LUT[nibble];

endmodule

// File: rtl/uart_loopback_top.sv
// Purpose: 8N1 UART echo with last-byte hex display (display built only with UART_SEG_DISPLAY_EN).
// Latency: echo start bit one cycle after rx_dv (~9.5 bit times after the RX start edge).
// Backpressure: none; one pending byte buffers an echo while TX is busy, newer bytes overwrite it.
module uart_loopback_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_uart_rx,
  output logic o_uart_tx,
  output logic o_Segment1_A,
  output logic o_Segment1_B,
  output logic o_Segment1_C,
  output logic o_Segment1_D,
  output logic o_Segment1_E,
  output logic o_Segment1_F,
  output logic o_Segment1_G,
  output logic o_Segment2_A,
  output logic o_Segment2_B,
  output logic o_Segment2_C,
  output logic o_Segment2_D,
  output logic o_Segment2_E,
  output logic o_Segment2_F,
  output logic o_Segment2_G
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta, rx_sync;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
    end
  end

  uart_state_t   rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_byte, rx_byte_n;
  logic          rx_dv, rx_dv_n;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_byte  <= '0;
      rx_dv    <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_byte  <= rx_byte_n;
      rx_dv    <= rx_dv_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_idx_n   = rx_idx;
    rx_byte_n  = rx_byte;
    rx_dv_n    = 1'b0;
    unique case (rx_state)
      ST_IDLE: begin
        rx_cnt_n = '0;
        rx_idx_n = '0;
        if (!rx_sync) rx_state_n = ST_START;
      end
      // Half-bit re-check rejects glitches shorter than half a bit.
      ST_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_state_n = rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n  = '0;
        rx_byte_n = {rx_sync, rx_byte[7:1]};
        rx_idx_n  = rx_idx + 3'd1;
        if (rx_idx == 3'd7) rx_state_n = ST_STOP;
      end
      ST_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_dv_n    = rx_sync;
        rx_state_n = ST_CLEANUP;
      end
      ST_CLEANUP: begin
        rx_cnt_n   = '0;
        rx_state_n = ST_IDLE;
      end
      default: rx_state_n = ST_IDLE;
    endcase
  end

  uart_state_t   tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_bit, tx_bit_n;
  logic          pend_vld, pend_vld_n;
  logic [7:0]    pend_byte, pend_byte_n;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tx_state  <= ST_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_bit    <= 1'b1;
      pend_vld  <= 1'b0;
      pend_byte <= '0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_idx    <= tx_idx_n;
      tx_shift  <= tx_shift_n;
      tx_bit    <= tx_bit_n;
      pend_vld  <= pend_vld_n;
      pend_byte <= pend_byte_n;
    end
  end

  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt + 1'b1;
    tx_idx_n    = tx_idx;
    tx_shift_n  = tx_shift;
    tx_bit_n    = tx_bit;
    pend_vld_n  = pend_vld;
    pend_byte_n = pend_byte;
    if (rx_dv && tx_state != ST_IDLE) begin
      pend_vld_n  = 1'b1;
      pend_byte_n = rx_byte;
    end
    unique case (tx_state)
      ST_IDLE: begin
        tx_cnt_n = '0;
        tx_idx_n = '0;
        tx_bit_n = 1'b1;
        // Older pending byte goes first; a same-cycle arrival takes its slot.
        if (pend_vld) begin
          tx_shift_n = pend_byte;
          tx_bit_n   = 1'b0;
          tx_state_n = ST_START;
          pend_vld_n = rx_dv;
          if (rx_dv) pend_byte_n = rx_byte;
        end else if (rx_dv) begin
          tx_shift_n = rx_byte;
          tx_bit_n   = 1'b0;
          tx_state_n = ST_START;
        end
      end
      ST_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_bit_n   = tx_shift[0];
        tx_state_n = ST_DATA;
      end
      ST_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        tx_bit_n   = tx_shift[1];
        tx_idx_n   = tx_idx + 3'd1;
        if (tx_idx == 3'd7) begin
          tx_bit_n   = 1'b1;
          tx_state_n = ST_STOP;
        end
      end
      ST_STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_state_n = ST_CLEANUP;
      end
      ST_CLEANUP: begin
        tx_cnt_n   = '0;
        tx_state_n = ST_IDLE;
      end
      default: tx_state_n = ST_IDLE;
    endcase
  end

  assign o_uart_tx = tx_bit;

  logic [6:0] seg_hi, seg_lo;

`ifdef UART_SEG_DISPLAY_EN
  logic [7:0] disp_byte;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)   disp_byte <= '0;
    else if (rx_dv) disp_byte <= rx_byte;
  end

  hex_to_7seg u_seg_hi (.nibble(disp_byte[7:4]), .seg_n(seg_hi));
  hex_to_7seg u_seg_lo (.nibble(disp_byte[3:0]), .seg_n(seg_lo));
`else
  assign seg_hi = '1;
  assign seg_lo = '1;
`endif

  assign {o_Segment1_A, o_Segment1_B, o_Segment1_C, o_Segment1_D,
          o_Segment1_E, o_Segment1_F, o_Segment1_G} = seg_hi;
  assign {o_Segment2_A, o_Segment2_B, o_Segment2_C, o_Segment2_D,
          o_Segment2_E, o_Segment2_F, o_Segment2_G} = seg_lo;

endmodule

// File: tb/tb_uart_loopback_top.sv
// Purpose: directed self-checking bench for the UART echo and hex display.
// Latency: checks echo start ~9.5 bit times after the RX start edge.
// Backpressure: exercises back-to-back frames through the pending byte.
module tb_uart_loopback_top;

  localparam int CPB = 217;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  wire        tx;
  wire  [6:0] seg1, seg2;

  int checks = 0;
  int errors = 0;

  uart_loopback_top #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_uart_rx(rx), .o_uart_tx(tx),
    .o_Segment1_A(seg1[6]), .o_Segment1_B(seg1[5]), .o_Segment1_C(seg1[4]),
    .o_Segment1_D(seg1[3]), .o_Segment1_E(seg1[2]), .o_Segment1_F(seg1[1]),
    .o_Segment1_G(seg1[0]),
    .o_Segment2_A(seg2[6]), .o_Segment2_B(seg2[5]), .o_Segment2_C(seg2[4]),
    .o_Segment2_D(seg2[3]), .o_Segment2_E(seg2[2]), .o_Segment2_F(seg2[1]),
    .o_Segment2_G(seg2[0])
  );

  always #20 clk = ~clk;

  // Lit pattern (A..G) to the expected pin levels for this build.
  function automatic logic [6:0] exp_seg(input logic [6:0] lit);
`ifdef UART_SEG_DISPLAY_EN
    return ~lit;
`else
    return lit | 7'h7f;
`endif
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    if (stop_bit) begin
      repeat (CPB) @(negedge clk);
    end else begin
      repeat (150) @(negedge clk);
      rx = 1'b1;
      repeat (CPB - 150) @(negedge clk);
    end
  endtask

  task automatic capture_byte(output logic [7:0] b, output bit seen,
                              output bit framed, output int lat);
    logic s0;
    b = '0; seen = 1'b0; framed = 1'b0; lat = 0; s0 = 1'b1;
    for (int n = 0; n < 2400 && !seen; n++) begin
      @(negedge clk);
      lat = n;
      if (tx === 1'b0) seen = 1'b1;
    end
    if (seen) begin
      repeat (CPB / 2) @(negedge clk);
      s0 = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      framed = (s0 === 1'b0) && (tx === 1'b1);
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx_held: got %b want 1", tx); end
    checks++; if (seg1 !== exp_seg(7'b1111110)) begin errors++; $display("FAIL reset_seg1_held: got %b want %b", seg1, exp_seg(7'b1111110)); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (seg1 !== exp_seg(7'b1111110)) begin errors++; $display("FAIL reset_seg1: got %b want %b", seg1, exp_seg(7'b1111110)); end
    checks++; if (seg2 !== exp_seg(7'b1111110)) begin errors++; $display("FAIL reset_seg2: got %b want %b", seg2, exp_seg(7'b1111110)); end
  endtask

  task automatic test_echo(input logic [7:0] val, input logic [6:0] hi_lit, input logic [6:0] lo_lit);
    logic [7:0] got;
    bit seen, framed;
    int lat;
    fork
      send_byte(val, 1'b1);
      capture_byte(got, seen, framed, lat);
    join
    checks++;
    if (!seen) begin
      errors++; $display("FAIL echo_%h_timeout: no start bit seen, want one", val);
    end else begin
      checks++; if (lat < 2050 || lat > 2080) begin errors++; $display("FAIL echo_%h_latency: got %0d want 2050..2080", val, lat); end
      checks++; if (!framed) begin errors++; $display("FAIL echo_%h_framing: got bad start/stop want good", val); end
      checks++; if (got !== val) begin errors++; $display("FAIL echo_%h_byte: got %h want %h", val, got, val); end
    end
    checks++; if (seg1 !== exp_seg(hi_lit)) begin errors++; $display("FAIL echo_%h_seg1: got %b want %b", val, seg1, exp_seg(hi_lit)); end
    checks++; if (seg2 !== exp_seg(lo_lit)) begin errors++; $display("FAIL echo_%h_seg2: got %b want %b", val, seg2, exp_seg(lo_lit)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got_a, got_b;
    bit seen_a, seen_b, fr_a, fr_b;
    int lat_a, lat_b;
    logic [6:0] mid1, mid2;
    fork
      begin
        send_byte(8'hFF, 1'b1);
        send_byte(8'h12, 1'b1);
      end
      begin
        capture_byte(got_a, seen_a, fr_a, lat_a);
        mid1 = seg1;
        mid2 = seg2;
        capture_byte(got_b, seen_b, fr_b, lat_b);
      end
    join
    checks++; if (!(seen_a && fr_a) || got_a !== 8'hFF) begin errors++; $display("FAIL b2b_first: got %h seen=%0d framed=%0d want ff", got_a, seen_a, fr_a); end
    checks++; if (!(seen_b && fr_b) || got_b !== 8'h12) begin errors++; $display("FAIL b2b_second: got %h seen=%0d framed=%0d want 12", got_b, seen_b, fr_b); end
    checks++; if (mid1 !== exp_seg(7'b1000111) || mid2 !== exp_seg(7'b1000111)) begin errors++; $display("FAIL b2b_disp_ff: got %b %b want %b %b", mid1, mid2, exp_seg(7'b1000111), exp_seg(7'b1000111)); end
    checks++; if (seg1 !== exp_seg(7'b0110000)) begin errors++; $display("FAIL b2b_seg1: got %b want %b", seg1, exp_seg(7'b0110000)); end
    checks++; if (seg2 !== exp_seg(7'b1101101)) begin errors++; $display("FAIL b2b_seg2: got %b want %b", seg2, exp_seg(7'b1101101)); end
  endtask

  task automatic test_glitch();
    int lows = 0;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL glitch_no_echo: got %0d low cycles want 0", lows); end
    checks++; if (seg2 !== exp_seg(7'b1101101)) begin errors++; $display("FAIL glitch_seg2: got %b want %b", seg2, exp_seg(7'b1101101)); end
  endtask

  task automatic test_framing_error();
    int lows = 0;
    fork
      send_byte(8'h55, 1'b0);
      repeat (4500) begin
        @(negedge clk);
        if (tx === 1'b0) lows++;
      end
    join
    checks++; if (lows != 0) begin errors++; $display("FAIL frame_err_no_echo: got %0d low cycles want 0", lows); end
    checks++; if (seg1 !== exp_seg(7'b0110000)) begin errors++; $display("FAIL frame_err_seg1: got %b want %b", seg1, exp_seg(7'b0110000)); end
    checks++; if (seg2 !== exp_seg(7'b1101101)) begin errors++; $display("FAIL frame_err_seg2: got %b want %b", seg2, exp_seg(7'b1101101)); end
  endtask

  task automatic test_reset_mid_tx();
    int lows = 0;
    send_byte(8'hA5, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midtx_active: got %b want 0", tx); end
    #5 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midtx_reset_tx: got %b want 1", tx); end
    checks++; if (seg1 !== exp_seg(7'b1111110) || seg2 !== exp_seg(7'b1111110)) begin errors++; $display("FAIL midtx_reset_seg: got %b %b want %b", seg1, seg2, exp_seg(7'b1111110)); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2500) begin
      @(negedge clk);
      if (tx === 1'b0) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL midtx_no_resume: got %0d low cycles want 0", lows); end
  endtask

  initial begin
    test_reset();
    test_echo(8'h31, 7'b1111001, 7'b0110000);
    test_echo(8'h4A, 7'b0110011, 7'b1110111);
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_echo(8'h5A, 7'b1011011, 7'b1110111);
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
